// File: rtl/muu_sequencer_if.sv
// Request/result bundle between the MIPS control path and the multiply/divide sequencer.
interface muu_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] rt;
  logic             wr_hi;
  logic             wr_lo;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             stall;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, rs, rt, wr_hi, wr_lo, wdata,
    input  busy, done, stall, div_zero, hi, lo
  );

  modport slave (
    input  start, op, rs, rt, wr_hi, wr_lo, wdata,
    output busy, done, stall, div_zero, hi, lo
  );
endinterface

// File: rtl/muu_sequencer.sv
// Iterative radix-2 multiply / restoring divide sequencer owning the architectural HI/LO registers.
// Stalls the PC while a MULT/MULTU/DIV/DIVU is in flight.
module muu_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  muu_sequencer_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] acc_q, low_q, dvs_q;
  logic [CW-1:0]    cnt_q;
  logic             neg_q, neg_rem_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             busy_q, done_q, dz_q;

  logic             accept, is_div_in, dz_in, rs_neg, rt_neg;
  logic [WIDTH-1:0] rs_mag, rt_mag;
  logic [WIDTH:0]   sum, shifted;
  logic [WIDTH-1:0] acc_nx, low_nx, res_hi, res_lo;
  logic [2*WIDTH-1:0] prod;

  // Request decode: signed ops work on operand magnitudes.
  always_comb begin
    accept    = (state_q == S_IDLE) && bus.start;
    is_div_in = bus.op[1];
    dz_in     = is_div_in && (bus.rt == '0);
    rs_neg    = ~bus.op[0] & bus.rs[WIDTH-1];
    rt_neg    = ~bus.op[0] & bus.rt[WIDTH-1];
    rs_mag    = rs_neg ? -bus.rs : bus.rs;
    rt_mag    = rt_neg ? -bus.rt : bus.rt;
  end

  // One shift-add or restoring-subtract iteration, plus the signed fix-up of its result.
  always_comb begin
    sum     = {1'b0, acc_q} + (low_q[0] ? {1'b0, dvs_q} : '0);
    shifted = {acc_q, low_q[WIDTH-1]};
    acc_nx  = sum[WIDTH:1];
    low_nx  = {sum[0], low_q[WIDTH-1:1]};
    if (op_q[1]) begin
      if (shifted >= {1'b0, dvs_q}) begin
        acc_nx = WIDTH'(shifted - {1'b0, dvs_q});
        low_nx = {low_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_nx = shifted[WIDTH-1:0];
        low_nx = {low_q[WIDTH-2:0], 1'b0};
      end
    end
    prod   = {acc_nx, low_nx};
    prod   = neg_q ? -prod : prod;
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
    if (op_q[1]) begin
      res_lo = neg_q ? -low_nx : low_nx;
      res_hi = neg_rem_q ? -acc_nx : acc_nx;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = dz_in ? S_DONE : S_RUN;
      S_RUN:   if (cnt_q == CW'(1)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Datapath and architectural registers; a start in IDLE drops a coincident MTHI/MTLO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= '0;
      acc_q     <= '0;
      low_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      busy_q <= (state_d == S_RUN);
      done_q <= (state_d == S_DONE);
      if (accept) begin
        op_q      <= bus.op;
        neg_q     <= rs_neg ^ rt_neg;
        neg_rem_q <= rs_neg;
        acc_q     <= '0;
        low_q     <= is_div_in ? rs_mag : rt_mag;
        dvs_q     <= is_div_in ? rt_mag : rs_mag;
        cnt_q     <= CW'(WIDTH);
        dz_q      <= dz_in;
        if (dz_in) begin
          hi_q <= bus.rs;
          lo_q <= '1;
        end
      end else if (state_q == S_IDLE) begin
        if (bus.wr_hi) hi_q <= bus.wdata;
        if (bus.wr_lo) lo_q <= bus.wdata;
      end else if (state_q == S_RUN) begin
        acc_q <= acc_nx;
        low_q <= low_nx;
        cnt_q <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          hi_q <= res_hi;
          lo_q <= res_lo;
        end
      end
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.div_zero = dz_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.stall    = busy_q | (bus.start & (state_q == S_IDLE));

endmodule

// File: tb/tb_muu_sequencer.sv
// Directed plus randomized bench for muu_sequencer against a 64-bit arithmetic reference model.
module tb_muu_sequencer;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  muu_sequencer_if #(.WIDTH(W)) bus ();
  muu_sequencer #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic        m_dz = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: what MIPS says HI/LO hold after the op, from plain 64-bit arithmetic.
  task automatic model_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, sq, sr;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    m_dz = 1'b0;
    case (op)
      2'd0: begin p = 64'(sa * sb); m_hi = p[63:32]; m_lo = p[31:0]; end
      2'd1: begin p = {32'd0, a} * {32'd0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
      default: begin
        if (b == 32'd0) begin
          m_dz = 1'b1; m_hi = a; m_lo = 32'hFFFF_FFFF;
        end else if (op == 2'd2) begin
          sq = sa / sb; sr = sa % sb;
          p = 64'(sq); m_lo = p[31:0];
          p = 64'(sr); m_hi = p[31:0];
        end else begin
          m_lo = a / b; m_hi = a % b;
        end
      end
    endcase
  endtask

  task automatic write_reg(input bit sel_hi, input logic [31:0] d);
    @(negedge clk);
    bus.wr_hi = sel_hi; bus.wr_lo = ~sel_hi; bus.wdata = d;
    @(posedge clk); #1;
    bus.wr_hi = 1'b0; bus.wr_lo = 1'b0;
    if (sel_hi) m_hi = d; else m_lo = d;
    check(sel_hi ? "mthi" : "mtlo", sel_hi ? bus.hi : bus.lo, d);
  endtask

  // inj: 0 plain, 1 MTHI pulse mid-RUN, 2 MTLO alongside start, 3 keep start held into DONE.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int inj);
    logic [31:0] old_hi, old_lo;
    int cyc, nbusy;
    bit divz;
    old_hi = m_hi; old_lo = m_lo;
    divz = op[1] && (b == 32'd0);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.rs = a; bus.rt = b;
    if (inj == 2) begin bus.wr_lo = 1'b1; bus.wdata = 32'h77; end
    #1 check({tag, "_stall_acc"}, bus.stall, 1);
    @(posedge clk); #1;
    if (inj != 3) bus.start = 1'b0;
    bus.wr_lo = 1'b0;
    cyc = 1; nbusy = 0;
    while (!bus.done && cyc < W + 8) begin
      nbusy += int'(bus.busy);
      check({tag, "_hold"}, {bus.hi, bus.lo}, {old_hi, old_lo});
      if (inj == 1 && cyc == 5) begin bus.wr_hi = 1'b1; bus.wdata = 32'h55; end
      else bus.wr_hi = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    bus.wr_hi = 1'b0;
    model_op(op, a, b);
    check({tag, "_done_cyc"}, 64'(cyc), divz ? 64'd1 : 64'(W + 1));
    check({tag, "_busy_cnt"}, 64'(nbusy), divz ? 64'd0 : 64'(W));
    check({tag, "_hi"}, bus.hi, m_hi);
    check({tag, "_lo"}, bus.lo, m_lo);
    check({tag, "_dz"}, bus.div_zero, m_dz);
    check({tag, "_stall_done"}, bus.stall, 0);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, bus.done, 0);
    check({tag, "_idle"}, bus.busy, 0);
    if (inj == 3) check({tag, "_stall_idle"}, bus.stall, 1);
  endtask

  initial begin
    logic [1:0] rop;
    logic [31:0] ra, rb;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.op = '0; bus.rs = '0; bus.rt = '0;
    bus.wr_hi = 1'b0; bus.wr_lo = 1'b0; bus.wdata = '0;
    #12;
    check("rst_hi", bus.hi, 0);
    check("rst_lo", bus.lo, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_dz", bus.div_zero, 0);
    check("rst_stall", bus.stall, 0);
    @(negedge clk); rst_n = 1'b1;

    run_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("mult_neg", 2'd0, 32'hFFFF_FFFD, 32'd7, 0);
    run_op("div_neg", 2'd2, 32'hFFFF_FFF9, 32'd2, 0);
    run_op("divu_zero", 2'd3, 32'd100, 32'd0, 0);
    run_op("divu_7", 2'd3, 32'd100, 32'd7, 0);
    run_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("div_zero_s", 2'd2, 32'hFFFF_FF00, 32'd0, 0);

    write_reg(1'b1, 32'h11);
    write_reg(1'b0, 32'h22);
    run_op("wr_in_run", 2'd1, 32'd2, 32'd3, 1);
    write_reg(1'b0, 32'h22);
    run_op("wr_with_start", 2'd1, 32'd2, 32'd3, 2);

    run_op("b2b_first", 2'd0, 32'd12345, 32'hFFFF_0000, 3);
    run_op("b2b_second", 2'd3, 32'hDEAD_BEEF, 32'd1000, 0);

    for (int i = 0; i < 24; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = -32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) ra = -32'($urandom_range(0, 1000));
      run_op("rand", rop, ra, rb, 0);
    end

    // Reset in the middle of a multiply discards it.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'd1; bus.rs = 32'd5; bus.rt = 32'd9;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    check("mid_busy", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    m_hi = '0; m_lo = '0; m_dz = 1'b0;
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_hi", bus.hi, 0);
    check("mid_rst_lo", bus.lo, 0);
    check("mid_rst_done", bus.done, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (30) begin
      @(posedge clk); #1;
      check("post_rst_no_done", bus.done, 0);
    end
    run_op("after_rst", 2'd1, 32'd6, 32'd7, 0);
    check("after_rst_42", bus.lo, 42);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
